// File: rtl/bsg_manycore_pkt_encode_buffered.sv
// rtl/bsg_manycore_pkt_encode_buffered.sv - buffered, credit-limited manycore request packet encoder

module bsg_manycore_pkt_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               s_tvalid,
  output logic               s_tready,
  input  logic [width_p-1:0] s_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic [width_p-1:0] m_tdata
);
  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic                enq, deq;

  // Full/empty come from registered occupancy only, so ready never follows a same-cycle dequeue
  assign s_tready = (count_q != cnt_w_lp'(els_p));
  assign m_tvalid = (count_q != '0);
  assign m_tdata  = mem_q[rd_ptr_q];
  assign enq      = s_tvalid & s_tready;
  assign deq      = m_tvalid & m_tready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = (wr_ptr_q == ptr_w_lp'(els_p - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (deq) rd_ptr_d = (rd_ptr_q == ptr_w_lp'(els_p - 1)) ? '0 : rd_ptr_q + 1'b1;
    if (enq & ~deq)      count_d = count_q + 1'b1;
    else if (~enq & deq) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr_q] <= s_tdata;
  end
endmodule

module bsg_manycore_pkt_encode_buffered #(
  parameter int x_cord_width_p    = 4,
  parameter int y_cord_width_p    = 4,
  parameter int data_width_p      = 32,
  parameter int addr_width_p      = 16,
  parameter int fifo_els_p        = 2,
  parameter int max_out_credits_p = 16,
  localparam int packet_width_lp  = addr_width_p + 2 + data_width_p/8 + data_width_p
                                    + 2*x_cord_width_p + 2*y_cord_width_p,
  localparam int credit_width_lp  = $clog2(max_out_credits_p + 1),
  localparam int addr_dec_width_lp = 1 + y_cord_width_p + x_cord_width_p + addr_width_p
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         v_i,
  output logic                         ready_o,
  input  logic [addr_dec_width_lp-1:0] addr_i,
  input  logic [data_width_p-1:0]      data_i,
  input  logic [data_width_p/8-1:0]    mask_i,
  input  logic                         we_i,
  input  logic [x_cord_width_p-1:0]    my_x_i,
  input  logic [y_cord_width_p-1:0]    my_y_i,
  output logic                         v_o,
  output logic [packet_width_lp-1:0]   data_o,
  input  logic                         ready_i,
  input  logic                         returned_credit_i,
  output logic [credit_width_lp-1:0]   out_credits_o,
  output logic                         idle_o
);
  typedef struct packed {
    logic                      remote;
    logic [y_cord_width_p-1:0] y_cord;
    logic [x_cord_width_p-1:0] x_cord;
    logic [addr_width_p-1:0]   addr;
  } addr_decode_s;

  typedef struct packed {
    logic [addr_width_p-1:0]   addr;
    logic [1:0]                op;
    logic [data_width_p/8-1:0] op_ex;
    logic [data_width_p-1:0]   data;
    logic [y_cord_width_p-1:0] from_y_cord;
    logic [x_cord_width_p-1:0] from_x_cord;
    logic [y_cord_width_p-1:0] y_cord;
    logic [x_cord_width_p-1:0] x_cord;
  } packet_s;

  localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

  addr_decode_s                addr_dec;
  packet_s                     pkt;
  logic                        fifo_ready, fifo_v, accept;
  logic [credit_width_lp-1:0]  credits_q, credits_d;
  logic                        stall_q, stall_d;
  logic [packet_width_lp-1:0]  hold_q, hold_d;

  assign addr_dec = addr_decode_s'(addr_i);
  assign ready_o  = fifo_ready & (credits_q != '0);
  assign accept   = v_i & addr_dec.remote & ready_o;

  // Top address bit selects the config space and is stripped from the packet address
  always_comb begin
    pkt             = '0;
    pkt.op          = addr_dec.addr[addr_width_p-1] ? 2'b10 : (we_i ? 2'b01 : 2'b00);
    pkt.op_ex       = mask_i;
    pkt.addr        = {1'b0, addr_dec.addr[addr_width_p-2:0]};
    pkt.data        = (pkt.op == 2'b00) ? '0 : data_i;
    pkt.x_cord      = addr_dec.x_cord;
    pkt.y_cord      = addr_dec.y_cord;
    pkt.from_x_cord = my_x_i;
    pkt.from_y_cord = my_y_i;
  end

  bsg_manycore_pkt_fifo #(
    .width_p (packet_width_lp),
    .els_p   (fifo_els_p)
  ) out_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .s_tvalid  (accept),
    .s_tready  (fifo_ready),
    .s_tdata   (pkt),
    .m_tvalid  (fifo_v),
    .m_tready  (ready_i),
    .m_tdata   (data_o)
  );

  assign v_o = fifo_v;

  always_comb begin
    credits_d = credits_q;
    if (accept & ~returned_credit_i)
      credits_d = credits_q - 1'b1;
    else if (~accept & returned_credit_i & (credits_q != max_credits_lp))
      credits_d = credits_q + 1'b1;
    stall_d = v_o & ~ready_i;
    hold_d  = data_o;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      credits_q <= max_credits_lp;
      stall_q   <= 1'b0;
    end else begin
      credits_q <= credits_d;
      stall_q   <= stall_d;
    end
    hold_q <= hold_d;
  end

  assign out_credits_o = credits_q;
  assign idle_o        = ~fifo_v & (credits_q == max_credits_lp);

  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(returned_credit_i & ~accept & (credits_q == max_credits_lp)))
        else $error("credit overflow: return with all credits available");
      assert (!stall_q || (v_o && data_o == hold_q))
        else $error("output packet changed while stalled");
    end
  end
endmodule

// File: tb/tb_bsg_manycore_pkt_encode_buffered.sv
// tb/tb_bsg_manycore_pkt_encode_buffered.sv - scoreboard bench for the buffered packet encoder

module tb_bsg_manycore_pkt_encode_buffered;
  localparam int PW = 70;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          v_i, ready_o, we_i, v_o, ready_i, returned_credit_i, idle_o;
  logic [24:0]   addr_i;
  logic [31:0]   data_i;
  logic [3:0]    mask_i, my_x, my_y;
  logic [PW-1:0] data_o;
  logic [4:0]    out_credits_o;

  logic          v2_i, ready2_o, v2_o, ready2_i, ret2, idle2_o;
  logic [PW-1:0] data2_o;
  logic [1:0]    credits2_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt2  = 0;
  logic [PW-1:0] sb_q [$];

  always #5 clk = ~clk;

  bsg_manycore_pkt_encode_buffered #(
    .x_cord_width_p(4), .y_cord_width_p(4), .data_width_p(32), .addr_width_p(16),
    .fifo_els_p(2), .max_out_credits_p(16)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .ready_o(ready_o), .addr_i(addr_i),
    .data_i(data_i), .mask_i(mask_i), .we_i(we_i), .my_x_i(my_x), .my_y_i(my_y),
    .v_o(v_o), .data_o(data_o), .ready_i(ready_i), .returned_credit_i(returned_credit_i),
    .out_credits_o(out_credits_o), .idle_o(idle_o)
  );

  bsg_manycore_pkt_encode_buffered #(
    .x_cord_width_p(4), .y_cord_width_p(4), .data_width_p(32), .addr_width_p(16),
    .fifo_els_p(2), .max_out_credits_p(2)
  ) dut2 (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v2_i), .ready_o(ready2_o), .addr_i(addr_i),
    .data_i(data_i), .mask_i(mask_i), .we_i(we_i), .my_x_i(my_x), .my_y_i(my_y),
    .v_o(v2_o), .data_o(data2_o), .ready_i(ready2_i), .returned_credit_i(ret2),
    .out_credits_o(credits2_o), .idle_o(idle2_o)
  );

  function automatic logic [PW-1:0] pkt(input logic [15:0] a, input logic [1:0] op,
                                        input logic [3:0] m, input logic [31:0] d,
                                        input logic [3:0] fy, input logic [3:0] fx,
                                        input logic [3:0] y, input logic [3:0] x);
    return {a, op, m, d, fy, fx, y, x};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && v_o && ready_i) begin
      if (sb_q.size() == 0) check("unexpected_packet", data_o, '0);
      else check("packet", data_o, sb_q.pop_front());
    end
    if (reset_n && v2_o && ready2_i) cnt2++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds the request until accepted; leaves v_i asserted so callers can chain back-to-back
  task automatic issue(input logic rem, input logic [3:0] y, input logic [3:0] x,
                       input logic [15:0] a, input logic [31:0] d, input logic [3:0] m,
                       input logic w, input logic [PW-1:0] exp, output int waits);
    v_i = 1'b1; addr_i = {rem, y, x, a}; data_i = d; mask_i = m; we_i = w;
    waits = 0;
    @(negedge clk);
    while (!ready_o && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!ready_o) check("issue_timeout", 0, 1);
    else sb_q.push_back(exp);
    step();
  endtask

  task automatic give_credit(input int n);
    returned_credit_i = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    returned_credit_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset_n = 1'b0; v_i = 1'b0; addr_i = '0; data_i = '0; mask_i = '0; we_i = 1'b0;
    my_x = 4'd1; my_y = 4'd2; ready_i = 1'b1; returned_credit_i = 1'b0;
    v2_i = 1'b0; ready2_i = 1'b1; ret2 = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_v_o", v_o, 0);
    check("reset_credits", out_credits_o, 16);
    check("reset_ready", ready_o, 1);
    check("reset_idle", idle_o, 1);
    step();

    issue(1, 4'd3, 4'd0, 16'h0004, 32'hDEADBEEF, 4'hF, 1,
          pkt(16'h0004, 2'b01, 4'hF, 32'hDEADBEEF, 4'd2, 4'd1, 4'd3, 4'd0), w);
    v_i = 1'b0;
    @(negedge clk);
    check("store_credits", out_credits_o, 15);
    check("store_v_o", v_o, 1);
    check("store_idle", idle_o, 0);
    step();
    give_credit(1);

    issue(1, 4'd1, 4'd2, 16'h0010, 32'h12345678, 4'h3, 0,
          pkt(16'h0010, 2'b00, 4'h3, 32'h0, 4'd2, 4'd1, 4'd1, 4'd2), w);
    issue(1, 4'd0, 4'd1, 16'h8020, 32'hCAFEF00D, 4'hF, 1,
          pkt(16'h0020, 2'b10, 4'hF, 32'hCAFEF00D, 4'd2, 4'd1, 4'd0, 4'd1), w);
    v_i = 1'b0;
    give_credit(2);
    step();

    v_i = 1'b1; addr_i = {1'b0, 4'd3, 4'd0, 16'h0004}; we_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("local_v_o", v_o, 0);
      check("local_credits", out_credits_o, 16);
      check("local_idle", idle_o, 1);
      step();
    end
    v_i = 1'b0;

    for (int i = 0; i < 4; i++) begin
      issue(1, 4'd5, 4'd6, 16'h0100 + 16'(i), 32'hA000_0000 + 32'(i), 4'h5, 1,
            pkt(16'h0100 + 16'(i), 2'b01, 4'h5, 32'hA000_0000 + 32'(i), 4'd2, 4'd1, 4'd5, 4'd6), w);
      check("throughput_wait", w, 0);
    end
    v_i = 1'b0;
    give_credit(4);

    ready_i = 1'b0;
    issue(1, 4'd7, 4'd7, 16'h0AAA, 32'h1111_2222, 4'h1, 1,
          pkt(16'h0AAA, 2'b01, 4'h1, 32'h1111_2222, 4'd2, 4'd1, 4'd7, 4'd7), w);
    issue(1, 4'd6, 4'd6, 16'h0BBB, 32'h3333_4444, 4'h2, 1,
          pkt(16'h0BBB, 2'b01, 4'h2, 32'h3333_4444, 4'd2, 4'd1, 4'd6, 4'd6), w);
    v_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready", ready_o, 0);
      check("bp_v_o", v_o, 1);
      check("bp_head", data_o, pkt(16'h0AAA, 2'b01, 4'h1, 32'h1111_2222, 4'd2, 4'd1, 4'd7, 4'd7));
      step();
    end
    ready_i = 1'b1;
    repeat (2) step();
    @(negedge clk);
    check("bp_drained", v_o, 0);
    step();
    give_credit(2);

    ready_i = 1'b0;
    issue(1, 4'd1, 4'd1, 16'h0055, 32'h5555_5555, 4'hF, 1,
          pkt(16'h0055, 2'b01, 4'hF, 32'h5555_5555, 4'd2, 4'd1, 4'd1, 4'd1), w);
    issue(1, 4'd1, 4'd1, 16'h0066, 32'h6666_6666, 4'hF, 1,
          pkt(16'h0066, 2'b01, 4'hF, 32'h6666_6666, 4'd2, 4'd1, 4'd1, 4'd1), w);
    v_i = 1'b0;
    give_credit(1);
    reset_n = 1'b0;
    sb_q.delete();
    step();
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_v_o", v_o, 0);
    check("rst_credits", out_credits_o, 16);
    check("rst_idle", idle_o, 1);
    step();
    ready_i = 1'b1;
    repeat (4) step();

    addr_i = {1'b1, 4'd2, 4'd2, 16'h0008}; data_i = 32'h0BAD_F00D; mask_i = 4'hF; we_i = 1'b1;
    v2_i = 1'b1;
    @(negedge clk);
    check("cr_init", credits2_o, 2);
    step();
    @(negedge clk);
    check("cr_one", credits2_o, 1);
    step();
    @(negedge clk);
    check("cr_zero", credits2_o, 0);
    check("cr_stall", ready2_o, 0);
    step();
    ret2 = 1'b1;
    @(negedge clk);
    check("cr_still_stall", ready2_o, 0);
    step();
    @(negedge clk);
    check("cr_returned", credits2_o, 1);
    check("cr_ready", ready2_o, 1);
    step();
    ret2 = 1'b0;
    @(negedge clk);
    check("cr_simul", credits2_o, 1);
    step();
    v2_i = 1'b0;
    @(negedge clk);
    check("cr_third", credits2_o, 0);
    repeat (4) step();
    check("cr_dequeued", cnt2, 4);
    check("sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
